// File: rtl/capturar_entrada.sv
// -----------------------------------------------------------------------------
// capturar_entrada
//   Front end of a vending machine: conditions the raw buttons and coin
//   pulses, collects a two-digit product code, validates it on confirm and
//   accumulates credit while the code is held.
//
//   Build option: define DEBOUNCE_EN to insert a counter debouncer
//   (DEB_CICLOS equal samples) between each synchronizer and its edge
//   detector. Without it the synchronized level feeds the edge detector.
//
// Ports
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   teclas[3:0]      raw digit buttons, bit i = digit i
//   confirmar        raw confirm button
//   cancelar         raw cancel / return-coins button
//   moeda25/50/100   raw coin pulses (+1/+2/+4 units of 0,25)
//   venda_ok         synchronous pulse: sale complete, clear the session
//   produto[3:0]     {d1,d2} of the confirmed code, 4'b1111 = invalid code
//   produto_valido   high while a valid confirmed code is held
//   valorMoedas[3:0] accumulated credit, 0..8
//   devolver         one-cycle pulse: return coins
//   moeda_rejeitada  one-cycle pulse: coin not accepted
// -----------------------------------------------------------------------------
module capturar_entrada #(
   parameter int unsigned DEB_CICLOS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] teclas,
   input  logic       confirmar,
   input  logic       cancelar,
   input  logic       moeda25,
   input  logic       moeda50,
   input  logic       moeda100,
   input  logic       venda_ok,
   output logic [3:0] produto,
   output logic       produto_valido,
   output logic [3:0] valorMoedas,
   output logic       devolver,
   output logic       moeda_rejeitada
);

   localparam int unsigned NIN = 9;

   typedef enum logic [1:0] {
      ESPERA_D1,
      ESPERA_D2,
      ESPERA_OK,
      PAGAMENTO
   } estado_t;

   // ---------------------------------------------------------------------
   // Input conditioning: synchronizer -> (debouncer) -> rising-edge detector
   // ---------------------------------------------------------------------
   logic [NIN-1:0] raw;
   logic [NIN-1:0] sync1_q, sync2_q;
   logic [NIN-1:0] filt;
   logic [NIN-1:0] prev_q;
   logic [NIN-1:0] arm_q;
   logic [1:0]     vld_q;
   logic [NIN-1:0] ev;

   assign raw = {moeda100, moeda50, moeda25, cancelar, confirmar, teclas};

   // arm_q blocks events on an input until it has been seen low after reset,
   // so a button held through reset does not fire when reset releases.
   // vld_q marks when sync2_q holds a real post-reset sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         arm_q   <= '0;
         vld_q   <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         prev_q  <= filt;
         arm_q   <= arm_q | ({NIN{vld_q[1]}} & ~sync2_q);
         vld_q   <= {vld_q[0], 1'b1};
      end
   end

`ifdef DEBOUNCE_EN
   localparam int unsigned CW = (DEB_CICLOS > 1) ? $clog2(DEB_CICLOS) : 1;

   logic [CW-1:0]  cnt_q [NIN];
   logic [NIN-1:0] stable_q;

   // cnt_q counts consecutive samples that differ from the accepted level;
   // the DEB_CICLOS-th differing sample makes the new level the accepted one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_q <= '0;
         for (int unsigned i = 0; i < NIN; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NIN; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CW'(DEB_CICLOS - 1)) begin
               stable_q[i] <= sync2_q[i];
               cnt_q[i]    <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + CW'(1);
            end
         end
      end
   end

   assign filt = stable_q;
`else
   assign filt = sync2_q;
`endif

   assign ev = filt & ~prev_q & arm_q;

   logic [3:0] ev_tec;
   logic       ev_ok, ev_can, ev_m25, ev_m50, ev_m100;

   assign ev_tec  = ev[3:0];
   assign ev_ok   = ev[4];
   assign ev_can  = ev[5];
   assign ev_m25  = ev[6];
   assign ev_m50  = ev[7];
   assign ev_m100 = ev[8];

   // ---------------------------------------------------------------------
   // Event decoding
   // ---------------------------------------------------------------------
   logic       tec_unico;
   logic [1:0] digito;
   logic       moeda_any, moeda_multi;
   logic [4:0] soma;

   assign tec_unico   = (ev_tec != 4'd0) && ((ev_tec & (ev_tec - 4'd1)) == 4'd0);
   assign moeda_any   = ev_m25 | ev_m50 | ev_m100;
   assign moeda_multi = (ev_m25 & ev_m50) | (ev_m25 & ev_m100) | (ev_m50 & ev_m100);

   // With a single coin event, {m100,m50,m25} is exactly its value (1/2/4).
   logic [3:0] valor_q;
   assign soma = {1'b0, valor_q} + {2'b00, ev_m100, ev_m50, ev_m25};

   always_comb begin
      digito = 2'd0;
      unique case (ev_tec)
         4'b0010: digito = 2'd1;
         4'b0100: digito = 2'd2;
         4'b1000: digito = 2'd3;
         default: digito = 2'd0;
      endcase
   end

   function automatic logic codigo_valido(input logic [3:0] c);
      case (c)
         4'b0000, 4'b0100, 4'b0101,
         4'b1000, 4'b1001, 4'b1010, 4'b1011,
         4'b1100, 4'b1101: codigo_valido = 1'b1;
         default:          codigo_valido = 1'b0;
      endcase
   endfunction

   // ---------------------------------------------------------------------
   // Session FSM
   // ---------------------------------------------------------------------
   estado_t    estado_q, estado_d;
   logic [1:0] d1_q, d1_d, d2_q, d2_d;
   logic [3:0] produto_q, produto_d, valor_d;
   logic       valido_q, valido_d;
   logic       devolver_q, devolver_d;
   logic       rej_q, rej_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q   <= ESPERA_D1;
         d1_q       <= '0;
         d2_q       <= '0;
         produto_q  <= '0;
         valido_q   <= 1'b0;
         valor_q    <= '0;
         devolver_q <= 1'b0;
         rej_q      <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         d1_q       <= d1_d;
         d2_q       <= d2_d;
         produto_q  <= produto_d;
         valido_q   <= valido_d;
         valor_q    <= valor_d;
         devolver_q <= devolver_d;
         rej_q      <= rej_d;
      end
   end

   // One branch per cycle, in priority order: cancel, sale done, coin,
   // confirm, digit. Lower-priority events in the same cycle are dropped.
   always_comb begin
      estado_d   = estado_q;
      d1_d       = d1_q;
      d2_d       = d2_q;
      produto_d  = produto_q;
      valido_d   = valido_q;
      valor_d    = valor_q;
      devolver_d = 1'b0;
      rej_d      = 1'b0;

      if (ev_can || venda_ok) begin
         devolver_d = ev_can && (valor_q != 4'd0);
         estado_d   = ESPERA_D1;
         d1_d       = '0;
         d2_d       = '0;
         produto_d  = '0;
         valido_d   = 1'b0;
         valor_d    = '0;
      end else if (moeda_any) begin
         if (moeda_multi || (estado_q != PAGAMENTO) || (soma > 5'd8)) begin
            rej_d = 1'b1;
         end else begin
            valor_d = soma[3:0];
         end
      end else if (ev_ok) begin
         if (estado_q == ESPERA_OK) begin
            if (codigo_valido({d1_q, d2_q})) begin
               produto_d = {d1_q, d2_q};
               valido_d  = 1'b1;
               estado_d  = PAGAMENTO;
            end else begin
               produto_d = '1;
               valido_d  = 1'b0;
               estado_d  = ESPERA_D1;
            end
         end
      end else if (tec_unico) begin
         case (estado_q)
            ESPERA_D1: begin
               d1_d     = digito;
               estado_d = ESPERA_D2;
               // a new entry replaces the invalid-code marker
               if (produto_q == 4'b1111) begin
                  produto_d = '0;
               end
            end
            ESPERA_D2: begin
               d2_d     = digito;
               estado_d = ESPERA_OK;
            end
            default: ;
         endcase
      end
   end

   assign produto         = produto_q;
   assign produto_valido  = valido_q;
   assign valorMoedas     = valor_q;
   assign devolver        = devolver_q;
   assign moeda_rejeitada = rej_q;

endmodule

// File: tb/tb_capturar_entrada.sv
// -----------------------------------------------------------------------------
// tb_capturar_entrada
//   Directed bench for capturar_entrada. A cycle model of the session rules
//   predicts every output; a compare process checks it each falling edge, and
//   literal expectations after each scenario pin the model.
// -----------------------------------------------------------------------------
module tb_capturar_entrada;

   localparam int DEB  = 4;
   localparam int HOLD = DEB + 6;

`ifdef DEBOUNCE_EN
   localparam bit DEBON = 1'b1;
`else
   localparam bit DEBON = 1'b0;
`endif

   localparam logic [8:0] K0   = 9'h001;
   localparam logic [8:0] K1   = 9'h002;
   localparam logic [8:0] K2   = 9'h004;
   localparam logic [8:0] K3   = 9'h008;
   localparam logic [8:0] OK   = 9'h010;
   localparam logic [8:0] CAN  = 9'h020;
   localparam logic [8:0] M25  = 9'h040;
   localparam logic [8:0] M50  = 9'h080;
   localparam logic [8:0] M100 = 9'h100;

   localparam int ST_D1  = 0;
   localparam int ST_D2  = 1;
   localparam int ST_OK  = 2;
   localparam int ST_PAG = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [8:0] raw = '0;
   logic       venda_ok = 1'b0;
   logic [3:0] produto, valorMoedas;
   logic       produto_valido, devolver, moeda_rejeitada;

   int n_tests = 0;
   int n_fail  = 0;
   int n_dev   = 0;
   int n_rej   = 0;

   always #5 clk = ~clk;

   capturar_entrada #(.DEB_CICLOS(DEB)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .teclas          (raw[3:0]),
      .confirmar       (raw[4]),
      .cancelar        (raw[5]),
      .moeda25         (raw[6]),
      .moeda50         (raw[7]),
      .moeda100        (raw[8]),
      .venda_ok        (venda_ok),
      .produto         (produto),
      .produto_valido  (produto_valido),
      .valorMoedas     (valorMoedas),
      .devolver        (devolver),
      .moeda_rejeitada (moeda_rejeitada)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Model
   // ---------------------------------------------------------------------
   logic [8:0] m_s1, m_s2, m_deb, m_dprev, m_arm;
   logic [8:0] m_hist [DEB];
   int         m_age;
   int         m_st, m_d1, m_d2, m_prod, m_val, m_credit, m_dev, m_rej;

   function automatic bit code_ok(input int c);
      return (c == 0) || (c == 4) || (c == 5) || (c >= 8 && c <= 13);
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      logic [8:0] filt, ev;
      int ntec, ncoin, cval, dig;
      bit same;
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_deb = '0; m_dprev = '0; m_arm = '0; m_age = 0;
         for (int k = 0; k < DEB; k++) m_hist[k] = '0;
         m_st = ST_D1; m_d1 = 0; m_d2 = 0; m_prod = 0; m_val = 0;
         m_credit = 0; m_dev = 0; m_rej = 0;
      end else begin
         filt = DEBON ? m_deb : m_s2;
         ev   = filt & ~m_dprev & m_arm;
         ntec  = $countones(ev[3:0]);
         ncoin = $countones(ev[8:6]);
         cval  = (ev[6] ? 1 : 0) + (ev[7] ? 2 : 0) + (ev[8] ? 4 : 0);
         m_dev = 0;
         m_rej = 0;
         if (ev[5] || venda_ok) begin
            if (ev[5] && m_credit != 0) m_dev = 1;
            m_st = ST_D1; m_d1 = 0; m_d2 = 0; m_prod = 0; m_val = 0; m_credit = 0;
         end else if (ncoin > 0) begin
            if (ncoin > 1 || m_st != ST_PAG || m_credit + cval > 8) m_rej = 1;
            else m_credit = m_credit + cval;
         end else if (ev[4]) begin
            if (m_st == ST_OK) begin
               if (code_ok(m_d1 * 4 + m_d2)) begin
                  m_prod = m_d1 * 4 + m_d2; m_val = 1; m_st = ST_PAG;
               end else begin
                  m_prod = 15; m_val = 0; m_st = ST_D1;
               end
            end
         end else if (ntec == 1) begin
            dig = 0;
            for (int b = 0; b < 4; b++) if (ev[b]) dig = b;
            if (m_st == ST_D1) begin
               m_d1 = dig; m_st = ST_D2;
               if (m_prod == 15) m_prod = 0;
            end else if (m_st == ST_D2) begin
               m_d2 = dig; m_st = ST_OK;
            end
         end
         // conditioning chain: a level is accepted once the last DEB
         // synchronized samples all agree
         if (m_age >= 2) m_arm = m_arm | ~m_s2;
         if (m_age < 2) m_age++;
         m_dprev = filt;
         for (int k = DEB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = m_s2;
         for (int b = 0; b < 9; b++) begin
            same = 1'b1;
            for (int k = 0; k < DEB; k++) if (m_hist[k][b] != m_hist[0][b]) same = 1'b0;
            if (same) m_deb[b] = m_hist[0][b];
         end
         m_s2 = m_s1;
         m_s1 = raw;
      end
   end

   // ---------------------------------------------------------------------
   // Per-cycle compare and pulse monitor
   // ---------------------------------------------------------------------
   always @(negedge clk) begin
      chk("cyc_produto", int'(produto), m_prod);
      chk("cyc_valido", int'(produto_valido), m_val);
      chk("cyc_valor", int'(valorMoedas), m_credit);
      chk("cyc_devolver", int'(devolver), m_dev);
      chk("cyc_rejeitada", int'(moeda_rejeitada), m_rej);
      if (devolver) n_dev++;
      if (moeda_rejeitada) n_rej++;
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   task automatic press(input logic [8:0] v);
      @(negedge clk);
      raw = v;
      repeat (HOLD) @(negedge clk);
      raw = '0;
      repeat (HOLD) @(negedge clk);
   endtask

   task automatic enter_code(input logic [8:0] a, input logic [8:0] b);
      press(a);
      press(b);
      press(OK);
   endtask

   task automatic check_all(input string nm, input int p, input int v, input int c);
      chk({nm, "_produto"}, int'(produto), p);
      chk({nm, "_valido"}, int'(produto_valido), v);
      chk({nm, "_valor"}, int'(valorMoedas), c);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : stim
      int r, d;
      // reset state, with moeda25 held high through reset
      raw = M25;
      repeat (3) @(negedge clk);
      check_all("reset", 0, 0, 0);
      chk("reset_devolver", int'(devolver), 0);
      chk("reset_rejeitada", int'(moeda_rejeitada), 0);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      raw = '0;
      repeat (HOLD) @(negedge clk);
      chk("held_through_reset_no_event", n_rej, 0);

      // digit 2, digit 1, confirm -> 1001 valid
      enter_code(K2, K1);
      check_all("code_1001", 9, 1, 0);

      // 4 + 4 = 8, then +1 rejected
      press(M100);
      chk("credit_4", int'(valorMoedas), 4);
      press(M100);
      chk("credit_8", int'(valorMoedas), 8);
      r = n_rej;
      press(M25);
      chk("overflow_rej_pulses", n_rej - r, 1);
      chk("overflow_credit", int'(valorMoedas), 8);

      d = n_dev;
      press(CAN);
      chk("cancel_dev_pulses", n_dev - d, 1);
      check_all("cancel", 0, 0, 0);

      // invalid code 3,3 -> 1111, coin outside payment rejected
      enter_code(K3, K3);
      check_all("code_invalid", 15, 0, 0);
      r = n_rej;
      press(M25);
      chk("coin_idle_rej_pulses", n_rej - r, 1);
      chk("coin_idle_credit", int'(valorMoedas), 0);
      press(K0);
      chk("overwrite_1111", int'(produto), 0);
      press(K0);
      press(OK);
      check_all("code_0000", 0, 1, 0);

      // 2 then cancel -> one devolver pulse
      press(M50);
      chk("credit_2", int'(valorMoedas), 2);
      d = n_dev;
      press(CAN);
      chk("cancel2_dev_pulses", n_dev - d, 1);
      check_all("cancel2", 0, 0, 0);

      // two keys at once ignored, confirm in ESPERA_D1 ignored
      press(K0 | K1);
      press(OK);
      check_all("multikey_ignored", 0, 0, 0);
      enter_code(K2, K1);
      check_all("code_after_multikey", 9, 1, 0);

      // two coins in one cycle -> one rejection
      r = n_rej;
      press(M25 | M50);
      chk("dual_coin_rej_pulses", n_rej - r, 1);
      chk("dual_coin_credit", int'(valorMoedas), 0);
`ifdef DEBOUNCE_EN
      @(negedge clk);
      raw = M100;
      repeat (2) @(negedge clk);
      raw = '0;
      repeat (2 * HOLD) @(negedge clk);
      chk("glitch_credit", int'(valorMoedas), 0);
      chk("glitch_rej_pulses", n_rej - r, 1);
`endif

      // cancel beats coin in the same cycle
      press(M25);
      chk("credit_1", int'(valorMoedas), 1);
      r = n_rej;
      d = n_dev;
      press(CAN | M25);
      chk("prio_dev_pulses", n_dev - d, 1);
      chk("prio_rej_pulses", n_rej - r, 0);
      check_all("prio", 0, 0, 0);

      // sale complete clears without devolver
      enter_code(K2, K1);
      press(M50);
      press(M25);
      chk("credit_3", int'(valorMoedas), 3);
      d = n_dev;
      @(negedge clk);
      venda_ok = 1'b1;
      @(negedge clk);
      venda_ok = 1'b0;
      repeat (3) @(negedge clk);
      chk("venda_dev_pulses", n_dev - d, 0);
      check_all("venda", 0, 0, 0);

      // exactly 8 accepted, 8 + 2 rejected
      enter_code(K3, K1);
      check_all("code_1101", 13, 1, 0);
      press(M100);
      press(M50);
      press(M50);
      chk("credit_exact_8", int'(valorMoedas), 8);
      r = n_rej;
      press(M50);
      chk("over8_rej_pulses", n_rej - r, 1);
      chk("over8_credit", int'(valorMoedas), 8);

      // asynchronous reset mid-payment
      press(CAN);
      enter_code(K1, K1);
      press(M50);
      press(M25);
      check_all("pre_reset", 5, 1, 3);
      d = n_dev;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_all("async_reset", 0, 0, 0);
      chk("async_reset_devolver", int'(devolver), 0);
      chk("async_reset_rejeitada", int'(moeda_rejeitada), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("reset_dev_pulses", n_dev - d, 0);
      check_all("post_reset", 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
